// File: rtl/vram_arbiter.sv
// Time-slot arbiter for the single-port video RAM: the video fetch owns one
// dot-clock slot per character period while DE is high, and the host gets every other slot.
module vram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int SLOTS    = 8,
  parameter int VID_SLOT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ph0,
  input  logic              i_de,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic [DATA_W-1:0] o_vid_data,
  output logic              o_vid_strobe,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
  localparam logic [SLOT_W-1:0] VID_IDX   = SLOT_W'(VID_SLOT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;

  state_t            r_state;
  state_t            w_next_state;
  tag_t              r_tag;
  logic              r_cpu_rd;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot;
  logic [DATA_W-1:0] r_vid_data;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              w_vid_issue;
  logic              w_cpu_issue;
  logic              w_cpu_rd_done;

  // ph0 takes effect in its own cycle, so the strobe cycle is always slot 0
  assign w_slot = i_ph0 ? '0 : r_slot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot <= '0;
    end else begin
      r_slot <= (w_slot == LAST_SLOT) ? w_slot : w_slot + 1'b1;
    end
  end

  assign w_vid_issue = (w_slot == VID_IDX) && i_de;
  assign w_cpu_issue = (r_state == ST_IDLE) && i_cpu_req && !w_vid_issue;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_cpu_issue) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_DONE;
      ST_DONE:  if (!i_cpu_req) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // RAM port is driven combinationally so an issue lands in the request cycle;
  // gating with i_rst_n keeps the port quiet while reset is asserted
  always_comb begin
    o_cpu_ack   = (r_state == ST_ISSUE);
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (i_rst_n) begin
      if (w_vid_issue) begin
        o_ram_en   = 1'b1;
        o_ram_addr = i_vid_addr;
      end else if (w_cpu_issue) begin
        o_ram_en    = 1'b1;
        o_ram_we    = i_cpu_we;
        o_ram_addr  = i_cpu_addr;
        o_ram_wdata = i_cpu_wdata;
      end
    end
  end

  // Capture is steered by the registered tag only, never by the current slot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag       <= TAG_NONE;
      r_cpu_rd    <= 1'b0;
      r_vid_data  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      if (w_vid_issue) begin
        r_tag <= TAG_VID;
      end else if (w_cpu_issue) begin
        r_tag <= TAG_CPU;
      end else begin
        r_tag <= TAG_NONE;
      end
      if (w_cpu_issue) begin
        r_cpu_rd <= !i_cpu_we;
      end
      if (o_vid_strobe) begin
        r_vid_data <= i_ram_rdata;
      end
      if (w_cpu_rd_done) begin
        r_cpu_rdata <= i_ram_rdata;
      end
    end
  end

  assign w_cpu_rd_done = (r_state == ST_ISSUE) && (r_tag == TAG_CPU) && r_cpu_rd;
  assign o_vid_strobe  = (r_tag == TAG_VID);
  assign o_vid_data    = o_vid_strobe ? i_ram_rdata : r_vid_data;
  assign o_cpu_rdata   = w_cpu_rd_done ? i_ram_rdata : r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a behavioural RAM, a ph0/slot model and
// scoreboards for video strobes and host acks with their expected cycles.
module tb_vram_arbiter;

  typedef struct {
    logic [15:0] data;
    int          due;
  } vidExp_t;

  typedef struct {
    logic        rd;
    logic [15:0] data;
    int          due;
  } cpuExp_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_ph0;
  logic        i_de;
  logic [12:0] i_vid_addr;
  logic [15:0] o_vid_data;
  logic        o_vid_strobe;
  logic        i_cpu_req;
  logic        i_cpu_we;
  logic [12:0] i_cpu_addr;
  logic [15:0] i_cpu_wdata;
  logic        o_cpu_ack;
  logic [15:0] o_cpu_rdata;
  logic        o_ram_en;
  logic        o_ram_we;
  logic [12:0] o_ram_addr;
  logic [15:0] o_ram_wdata;
  logic [15:0] i_ram_rdata;

  logic [15:0] mem  [0:8191];
  logic [15:0] gold [0:8191];
  vidExp_t     vidQ [$];
  cpuExp_t     cpuQ [$];

  int          vectors;
  int          miscompares;
  int          cyc;
  int          benchSlot;
  int          enCount;
  int          enMark;
  logic        ph0En;
  logic        forcePh0;
  logic        de;
  logic [12:0] vidAddr;
  logic        cpuReq;
  logic        cpuWe;
  logic [12:0] cpuAddr;
  logic [15:0] cpuWdata;

  vram_arbiter #(
    .ADDR_W(13), .DATA_W(16), .SLOTS(8), .VID_SLOT(2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ph0       (i_ph0),
    .i_de        (i_de),
    .i_vid_addr  (i_vid_addr),
    .o_vid_data  (o_vid_data),
    .o_vid_strobe(o_vid_strobe),
    .i_cpu_req   (i_cpu_req),
    .i_cpu_we    (i_cpu_we),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_wdata (i_cpu_wdata),
    .o_cpu_ack   (o_cpu_ack),
    .o_cpu_rdata (o_cpu_rdata),
    .o_ram_en    (o_ram_en),
    .o_ram_we    (o_ram_we),
    .o_ram_addr  (o_ram_addr),
    .o_ram_wdata (o_ram_wdata),
    .i_ram_rdata (i_ram_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous single-port RAM: read data appears the cycle after ram_en
  always @(posedge i_clk) begin
    if (o_ram_en) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      else          i_ram_rdata     <= mem[o_ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      $error("[TB] %s miscompare", tag);
    end
  endtask

  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
    cyc++;
    i_ph0       = forcePh0 || (ph0En && (cyc % 8 == 0));
    forcePh0    = 1'b0;
    i_de        = de;
    i_vid_addr  = vidAddr;
    i_cpu_req   = cpuReq;
    i_cpu_we    = cpuWe;
    i_cpu_addr  = cpuAddr;
    i_cpu_wdata = cpuWdata;
    if (!i_rst_n || i_ph0) benchSlot = 0;
    else if (benchSlot < 7) benchSlot++;
    if (i_rst_n && i_de && benchSlot == 2) vidQ.push_back('{gold[vidAddr], cyc + 1});
  endtask

  task automatic scoreboardCheck();
    vidExp_t v;
    cpuExp_t c;
    if (o_ram_en) enCount++;
    if (vidQ.size() > 0 && vidQ[0].due < cyc) begin
      checkOutput("vid_missing", 64'(vidQ[0].due), 64'(cyc));
      void'(vidQ.pop_front());
    end
    if (cpuQ.size() > 0 && cpuQ[0].due < cyc) begin
      checkOutput("ack_missing", 64'(cpuQ[0].due), 64'(cyc));
      void'(cpuQ.pop_front());
    end
    if (o_vid_strobe) begin
      if (vidQ.size() == 0) checkOutput("vid_unexpected", o_vid_strobe, 0);
      else begin
        v = vidQ.pop_front();
        checkOutput("vid_cycle", 64'(cyc), 64'(v.due));
        checkOutput("vid_data", o_vid_data, v.data);
      end
    end
    if (o_cpu_ack) begin
      if (cpuQ.size() == 0) checkOutput("ack_unexpected", o_cpu_ack, 0);
      else begin
        c = cpuQ.pop_front();
        checkOutput("ack_cycle", 64'(cyc), 64'(c.due));
        if (c.rd) checkOutput("cpu_rdata", o_cpu_rdata, c.data);
      end
    end
  endtask

  task automatic step();
    applyStimulus();
    #3;
    scoreboardCheck();
  endtask

  task automatic runTo(input int target);
    while (cyc < target) step();
  endtask

  task automatic hostRequest(input logic we, input logic [12:0] addr, input logic [15:0] wdata,
                             input int due);
    cpuReq   = 1'b1;
    cpuWe    = we;
    cpuAddr  = addr;
    cpuWdata = wdata;
    cpuQ.push_back('{!we, gold[addr], due});
    if (we) gold[addr] = wdata;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = -1; benchSlot = 0; enCount = 0; enMark = 0;
    ph0En = 1'b1; forcePh0 = 1'b0; de = 1'b0; vidAddr = '0;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
    i_rst_n = 1'b0; i_ph0 = 1'b0; i_de = 1'b0; i_vid_addr = '0;
    i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = '0; i_cpu_wdata = '0;
    i_ram_rdata = '0;
    for (int i = 0; i < 8192; i++) begin
      mem[i]  = 16'(i * 7 + 3);
      gold[i] = 16'(i * 7 + 3);
    end
    mem[13'h0123] = 16'hA55A; gold[13'h0123] = 16'hA55A;
    mem[13'h0010] = 16'h1234; gold[13'h0010] = 16'h1234;

    #2;
    checkOutput("reset_data", {o_vid_data, o_cpu_rdata, o_ram_wdata}, 0);
    checkOutput("reset_ctrl", {o_vid_strobe, o_cpu_ack, o_ram_en, o_ram_we, o_ram_addr}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    runTo(5);
    checkOutput("idle_ram_en", o_ram_en, 0);

    // Video fetch of 0x0123 in slot 2
    runTo(7);
    de = 1'b1; vidAddr = 13'h0123;
    runTo(10);
    checkOutput("vid_issue", {o_ram_en, o_ram_we, o_ram_addr}, {1'b1, 1'b0, 13'h0123});

    // Host write in free slot 5
    runTo(20);
    hostRequest(1'b1, 13'h1FFF, 16'hBEEF, 22);
    step();
    checkOutput("wr_issue", {o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata},
                {1'b1, 1'b1, 13'h1FFF, 16'hBEEF});
    runTo(22);
    cpuReq = 1'b0;

    // Host read colliding with the video slot, video now fetches 0x1FFF
    runTo(23);
    vidAddr = 13'h1FFF;
    runTo(25);
    hostRequest(1'b0, 13'h0010, 16'h0000, 28);
    step();
    checkOutput("collide_vid", {o_ram_en, o_ram_we, o_ram_addr}, {1'b1, 1'b0, 13'h1FFF});
    step();
    checkOutput("collide_host", {o_ram_en, o_ram_we, o_ram_addr}, {1'b1, 1'b0, 13'h0010});
    runTo(28);
    cpuReq = 1'b0;

    // Blanking: host owns slot 2
    runTo(31);
    de = 1'b0;
    runTo(33);
    hostRequest(1'b0, 13'h0123, 16'h0000, 35);
    step();
    checkOutput("blank_issue", {o_ram_en, o_ram_we, o_ram_addr}, {1'b1, 1'b0, 13'h0123});
    runTo(35);
    cpuReq = 1'b0;

    // Request held long after ack: one access, then a second after re-raise
    runTo(40);
    enMark = enCount;
    hostRequest(1'b0, 13'h1FFF, 16'h0000, 42);
    runTo(52);
    checkOutput("hold_accesses", 64'(enCount - enMark), 1);
    cpuReq = 1'b0;
    runTo(54);
    enMark = enCount;
    hostRequest(1'b1, 13'h0010, 16'h5678, 56);
    runTo(56);
    cpuReq = 1'b0;
    runTo(57);
    checkOutput("rearm_accesses", 64'(enCount - enMark), 1);

    // Mid-period ph0 resync, then saturation with ph0 withheld
    de = 1'b1; vidAddr = 13'h0010;
    runTo(59);
    forcePh0 = 1'b1;
    runTo(72);
    ph0En = 1'b0;
    runTo(95);
    ph0En = 1'b1;
    runTo(99);
    de = 1'b0;

    // Reset in the middle of a host access
    runTo(100);
    hostRequest(1'b0, 13'h1FFF, 16'h0000, 102);
    step();
    checkOutput("pre_reset_issue", o_ram_en, 1);
    i_rst_n = 1'b0;
    cpuReq  = 1'b0;
    #1;
    checkOutput("async_reset_data", {o_vid_data, o_cpu_rdata, o_ram_wdata}, 0);
    checkOutput("async_reset_ctrl", {o_vid_strobe, o_cpu_ack, o_ram_en, o_ram_we, o_ram_addr}, 0);
    void'(cpuQ.pop_back());
    step();
    i_rst_n = 1'b1;
    runTo(104);
    hostRequest(1'b0, 13'h1FFF, 16'h0000, 106);
    runTo(106);
    cpuReq = 1'b0;
    runTo(112);

    checkOutput("vid_queue_empty", 64'(vidQ.size()), 0);
    checkOutput("cpu_queue_empty", 64'(cpuQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Time-slot arbiter sharing the single-port video RAM between the display fetch path and a host (CPU) port. Each character period is divided into SLOTS dot-clock slots, and the video fetch owns slot VID_SLOT while DE is high. The host gets every other slot, and all slots during blanking. The block sits between the vdu/vmatrix fetch path and the vram primitive, and carries the host traffic that the future bus switch will route.

Parameters:
ADDR_W, 13, VRAM word address width
DATA_W, 16, VRAM word width
SLOTS, 8, dot clocks per character period (slot counter range 0..SLOTS-1)
VID_SLOT, 2, slot reserved for the video fetch (0 <= VID_SLOT < SLOTS-1)

Ports:
clk  in  1  dot clock; the only clock
rst_n  in  1  asynchronous active-low reset
ph0  in  1  one-cycle strobe marking the start of a character period
de  in  1  display enable from the video controller
vid_addr  in  ADDR_W  video fetch address, stable across the slot
vid_data  out  DATA_W  last fetched video word
vid_strobe  out  1  one-cycle pulse: vid_data updated
cpu_req  in  1  host request level (4-phase handshake)
cpu_we  in  1  1 = write, 0 = read; held with cpu_req
cpu_addr  in  ADDR_W  host word address, held with cpu_req
cpu_wdata  in  DATA_W  host write data, held with cpu_req
cpu_ack  out  1  one-cycle pulse: host access complete
cpu_rdata  out  DATA_W  host read data, valid in the cpu_ack cycle and held until the next read completes
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable (only with ram_en)
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  synchronous RAM read data, valid the cycle after ram_en with ram_we=0

Behaviour:
- Reset (async, rst_n=0): slot=0, FSM=IDLE; outputs vid_data, vid_strobe, cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata all 0; capture tag=NONE.
- Slot counter:
  - ph0=1 forces slot to 0.
  - Otherwise slot increments and saturates at SLOTS-1; it does not wrap without ph0.
  - ph0 mid-period resyncs immediately.
- Video slot:
  - When slot==VID_SLOT and de=1, the block drives ram_en=1, ram_we=0, ram_addr=vid_addr and sets the capture tag to VID.
  - Next cycle: vid_data<=ram_rdata and vid_strobe=1 for one cycle.
  - When de=0, VID_SLOT is a host slot.
- Host FSM states: IDLE, ISSUE, DONE.
  - IDLE: if cpu_req=1 and the current slot is a host slot, drive ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr, ram_wdata=cpu_wdata, set tag=CPU, and go to ISSUE. Otherwise wait.
  - ISSUE (exactly 1 cycle): pulse cpu_ack. If it was a read, cpu_rdata<=ram_rdata in this cycle. Go to DONE.
  - ISSUE cycle may coincide with the video slot (RAM is pipelined). A new video issue and the host capture happen in the same cycle without conflict.
  - DONE: wait for cpu_req=0, then go to IDLE. This prevents a double issue on a held request.
- Latency: request in a host slot gets ram_en in the same cycle and cpu_ack 1 cycle later. A request arriving in the video slot during DE is deferred to slot VID_SLOT+1 (1-cycle stall). The worst case is 2 cycles from cpu_req to cpu_ack.
- Priority: video always wins the video slot during DE. Host never sees starvation beyond 1 cycle per character period.
- ram_en is 0 in any cycle with no issue; ram_we is never 1 without ram_en.
- Capture uses only the registered tag, never a recomputed slot, so a ph0 resync between issue and capture is harmless.
- Simultaneous de falling in VID_SLOT: de is sampled in that cycle; de=0 means a host slot.
- cpu_req dropped while in ISSUE: the access still completes and ack still pulses, then the FSM returns to IDLE via DONE.
- Reset mid-access: everything returns to reset values. No ack is produced; the host retries.

Test Plan:
- Reset: rst_n=0 mid-run, asynchronous -> all outputs 0 within the same cycle with no clock edge; after release with ph0 every 8 clocks, slot sequence 0..7 repeats.
- Video fetch: de=1, vid_addr=0x0123, RAM[0x0123]=0xA55A -> ram_en at slot 2 with ram_addr=0x0123 and ram_we=0; slot 3 gives vid_strobe=1, vid_data=0xA55A; one strobe per character period.
- Host write in a free slot: cpu_req at slot 5, we=1, addr=0x1FFF, wdata=0xBEEF -> same cycle ram_en=1, ram_we=1, ram_addr=0x1FFF; next cycle cpu_ack=1; a later video fetch of 0x1FFF returns 0xBEEF.
- Host read colliding with the video slot: de=1, read addr=0x0010 (=0x1234) raised at slot 2 -> video owns slot 2, host issues at slot 3, cpu_ack at slot 4 with cpu_rdata=0x1234; vid_strobe at slot 3 remains correct.
- Blanking: de=0, host read raised at slot 2 -> issued at slot 2, no vid_strobe that period.
- Handshake hold: cpu_req held high for 10 cycles after ack -> exactly one RAM access and one cpu_ack; after req drops and rises again -> a second access.
